// File: rtl/xor32_pkg.sv
// Shared constants and FSM encoding for the xorshift32 random bank.
// Seed zero-guard constant is used when XOR32_ZERO_GUARD_EN is defined.
package xor32_pkg;

  localparam int unsigned SH_A = 13;
  localparam int unsigned SH_B = 17;
  localparam int unsigned SH_C = 5;

  localparam logic [31:0] ZERO_GUARD = 32'h2545F491;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/xor32_step.sv
// One combinational xorshift32 step for a single 32-bit lane.
// Logical shifts, results truncated to 32 bits.
module xor32_step
  import xor32_pkg::*;
(
  input  logic [31:0] iX,
  output logic [31:0] oY
);

  logic [31:0] t0;
  logic [31:0] t1;

  assign t0 = iX ^ (iX << SH_A);
  assign t1 = t0 ^ (t0 >> SH_B);
  assign oY = t1 ^ (t1 << SH_C);

endmodule

// File: rtl/xor32_random_bank.sv
// SIZE-lane xorshift32 bank: load, optional warm-up, then one step per beat.
// Optional macro XOR32_ZERO_GUARD_EN replaces zero seed words on load.
module xor32_random_bank
  import xor32_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int WARMUP = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [SIZE*32-1:0] iInit,
  input  logic              iLoad,
  input  logic              iReady,
  output logic              oValid,
  output logic [SIZE*32-1:0] oRand
);

  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] WLAST =
    CW'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_e              fsm_q, fsm_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SIZE*32-1:0]  st_q, st_d;
  logic [SIZE*32-1:0]  st_step;
  logic [SIZE*32-1:0]  st_seed;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    xor32_step u_step (
      .iX (st_q[i*32 +: 32]),
      .oY (st_step[i*32 +: 32])
    );
`ifdef XOR32_ZERO_GUARD_EN
    assign st_seed[i*32 +: 32] =
      (iInit[i*32 +: 32] == 32'd0) ? ZERO_GUARD
                                   : iInit[i*32 +: 32];
`else
    assign st_seed[i*32 +: 32] = iInit[i*32 +: 32];
`endif
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    unique case (1'b1)
      (fsm_q == ST_LOAD): begin
        st_d  = st_seed;
        cnt_d = '0;
        fsm_d = (WARMUP > 0) ? ST_WARM : ST_RUN;
      end
      (fsm_q == ST_WARM): begin
        st_d  = st_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WLAST) fsm_d = ST_RUN;
      end
      (fsm_q == ST_RUN): begin
        if (iReady) st_d = st_step;
      end
      default: fsm_d = ST_LOAD;
    endcase
    // Reload wins over any step; only LOAD itself samples iInit
    if (iLoad) begin
      fsm_d = ST_LOAD;
      cnt_d = '0;
      if (fsm_q != ST_LOAD) st_d = st_q;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fsm_q <= ST_LOAD;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign oValid = (fsm_q == ST_RUN);
  assign oRand  = st_q;

endmodule
